// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle ops finish in one cycle. Shifts and multiply run iteratively
// in BUSY, one bit per cycle. All outputs are registered.
module alu_mc #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned SWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SWIDTH-1:0] sel,
  input  logic [DWIDTH-1:0] src1,
  input  logic [DWIDTH-1:0] src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] res,
  output logic              res_is_0,
  output logic              illegal
);

  localparam int unsigned SHW = $clog2(DWIDTH);
  // The counter must be able to hold DWIDTH, the multiply iteration count
  localparam int unsigned CW  = $clog2(DWIDTH + 1);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DWIDTH-1:0] a_q, a_d;     // shift operand / shifted multiplicand
  logic [DWIDTH-1:0] b_q, b_d;     // remaining multiplier bits
  logic [DWIDTH-1:0] acc_q, acc_d; // multiply partial sum
  logic [DWIDTH-1:0] res_d;
  logic              zero_d;
  logic              illegal_d;

  logic [SHW-1:0]    amt;
  logic              sel_illegal;
  logic              start_iter;
  logic [DWIDTH-1:0] fast_res;
  logic [DWIDTH-1:0] step;

  // Decode the incoming request and compute the single-cycle result
  always_comb begin
    amt         = src2[SHW-1:0];
    sel_illegal = ((sel >> 3) != '0);
    start_iter  = (sel[2:0] == OP_MUL) ||
                  (((sel[2:0] == OP_SLL) || (sel[2:0] == OP_SRL)) && (amt != '0));
    fast_res    = src1;  // shifts by zero pass src1 through
    case (sel[2:0])
      OP_AND:  fast_res = src1 & src2;
      OP_OR:   fast_res = src1 | src2;
      OP_ADD:  fast_res = src1 + src2;
      OP_SUB:  fast_res = src1 + ~src2 + DWIDTH'(1);
      OP_SLT:  fast_res = DWIDTH'(src1 < src2);
      default: fast_res = src1;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    res_d     = res;
    zero_d    = res_is_0;
    illegal_d = illegal;
    step      = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d      = sel[2:0];
          illegal_d = 1'b0;
          if (sel_illegal) begin
            state_d   = DONE;
            res_d     = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
          end else if (start_iter) begin
            state_d = BUSY;
            a_d     = src1;
            b_d     = src2;
            acc_d   = '0;
            cnt_d   = (sel[2:0] == OP_MUL) ? CW'(DWIDTH) : CW'(amt);
          end else begin
            state_d = DONE;
            res_d   = fast_res;
            zero_d  = (fast_res == '0);
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        case (op_q)
          OP_SLL: begin
            step = a_q << 1;
            a_d  = step;
          end
          OP_SRL: begin
            step = a_q >> 1;
            a_d  = step;
          end
          default: begin
            step  = acc_q + (b_q[0] ? a_q : '0);
            acc_d = step;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end
        endcase
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_d   = step;
          zero_d  = (step == '0);
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      res       <= '0;
      res_is_0  <= 1'b0;
      illegal   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      res       <= res_d;
      res_is_0  <= zero_d;
      illegal   <= illegal_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (DWIDTH=8, SWIDTH=4).
module tb_alu_mc;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sel;
  logic [DW-1:0] src1;
  logic [DW-1:0] src2;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] res;
  logic          res_is_0;
  logic          illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [SW-1:0] s;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] r;
    int            lat;
  } vec_t;

  alu_mc #(.DWIDTH(DW), .SWIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_is_0  (res_is_0),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and count cycles until out_valid
  task automatic do_op(input logic [SW-1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output int lat, output bit saw_ready);
    sel = s; src1 = a; src2 = b; in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    lat       = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    total++; if (res !== 8'h00) begin bad++; $display("FAIL reset res got %h want 00", res); end
    total++; if (res_is_0 !== 1'b0) begin bad++; $display("FAIL reset res_is_0 got %b want 0", res_is_0); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset illegal got %b want 0", illegal); end
  endtask

  task automatic test_single();
    vec_t v[8];
    int   lat;
    bit   sr;
    v[0] = '{4'd2, 8'hF0, 8'h20, 8'h10, 1};
    v[1] = '{4'd6, 8'h05, 8'h05, 8'h00, 1};
    v[2] = '{4'd7, 8'd3,  8'd200, 8'h01, 1};
    v[3] = '{4'd7, 8'd200, 8'd3,  8'h00, 1};
    v[4] = '{4'd0, 8'hCC, 8'hAA, 8'h88, 1};
    v[5] = '{4'd1, 8'hC0, 8'h0A, 8'hCA, 1};
    v[6] = '{4'd6, 8'h03, 8'h05, 8'hFE, 1};
    v[7] = '{4'd2, 8'hFF, 8'h01, 8'h00, 1};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].s, v[i].a, v[i].b, lat, sr);
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL single[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      total++; if (res !== v[i].r) begin bad++; $display("FAIL single[%0d] res got %h want %h", i, res, v[i].r); end
      total++; if (res_is_0 !== (v[i].r == 8'h00)) begin bad++; $display("FAIL single[%0d] res_is_0 got %b want %b", i, res_is_0, (v[i].r == 8'h00)); end
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL single[%0d] illegal got %b want 0", i, illegal); end
      retire();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL single[%0d] retire in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_shift();
    vec_t v[5];
    int   lat;
    bit   sr;
    v[0] = '{4'd3, 8'h81, 8'h03, 8'h08, 4};
    v[1] = '{4'd4, 8'hA5, 8'hF8, 8'hA5, 1};
    v[2] = '{4'd4, 8'h80, 8'h0F, 8'h01, 8};
    v[3] = '{4'd3, 8'h81, 8'h09, 8'h02, 2};
    v[4] = '{4'd3, 8'h00, 8'hF8, 8'h00, 1};
    for (int i = 0; i < 5; i++) begin
      do_op(v[i].s, v[i].a, v[i].b, lat, sr);
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL shift[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      total++; if (res !== v[i].r) begin bad++; $display("FAIL shift[%0d] res got %h want %h", i, res, v[i].r); end
      total++; if (res_is_0 !== (v[i].r == 8'h00)) begin bad++; $display("FAIL shift[%0d] res_is_0 got %b want %b", i, res_is_0, (v[i].r == 8'h00)); end
      total++; if (sr !== 1'b0) begin bad++; $display("FAIL shift[%0d] in_ready while busy got 1 want 0", i); end
      retire();
    end
  endtask

  task automatic test_mul();
    vec_t v[4];
    int   lat;
    bit   sr;
    v[0] = '{4'd5, 8'd13, 8'd21, 8'h11, 9};
    v[1] = '{4'd5, 8'hFF, 8'hFF, 8'h01, 9};
    v[2] = '{4'd5, 8'h10, 8'h10, 8'h00, 9};
    v[3] = '{4'd5, 8'h07, 8'h00, 8'h00, 9};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].s, v[i].a, v[i].b, lat, sr);
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL mul[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      total++; if (res !== v[i].r) begin bad++; $display("FAIL mul[%0d] res got %h want %h", i, res, v[i].r); end
      total++; if (res_is_0 !== (v[i].r == 8'h00)) begin bad++; $display("FAIL mul[%0d] res_is_0 got %b want %b", i, res_is_0, (v[i].r == 8'h00)); end
      total++; if (sr !== 1'b0) begin bad++; $display("FAIL mul[%0d] in_ready while busy got 1 want 0", i); end
      retire();
    end
  endtask

  task automatic test_illegal();
    vec_t v[3];
    int   lat;
    bit   sr;
    v[0] = '{4'b1010, 8'h05, 8'h06, 8'h00, 1};
    v[1] = '{4'b1111, 8'hFF, 8'hFF, 8'h00, 1};
    v[2] = '{4'b1101, 8'h0D, 8'h15, 8'h00, 1};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].s, v[i].a, v[i].b, lat, sr);
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL illegal[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
      total++; if (res !== v[i].r) begin bad++; $display("FAIL illegal[%0d] res got %h want %h", i, res, v[i].r); end
      total++; if (res_is_0 !== 1'b1) begin bad++; $display("FAIL illegal[%0d] res_is_0 got %b want 1", i, res_is_0); end
      total++; if (illegal !== 1'b1) begin bad++; $display("FAIL illegal[%0d] illegal got %b want 1", i, illegal); end
      retire();
    end
  endtask

  task automatic test_hold();
    int lat;
    bit sr;
    do_op(4'd2, 8'h01, 8'h02, lat, sr);
    total++; if (lat !== 1) begin bad++; $display("FAIL hold latency got %0d want 1", lat); end
    // In DONE with out_ready low: result frozen, new requests ignored
    sel = 4'd2; src1 = 8'h09; src2 = 8'h09; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || res !== 8'h03 || in_ready !== 1'b0) begin
        bad++; $display("FAIL hold[%0d] out_valid=%b res=%h in_ready=%b want 1/03/0", k, out_valid, res, in_ready);
      end
    end
    // Retire with in_valid still high: retired, not accepted
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold retire out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold no-accept out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    int lat;
    bit sr;
    sel = 4'd5; src1 = 8'd13; src2 = 8'd21; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid in_ready got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0 || res !== 8'h00 || res_is_0 !== 1'b0 || illegal !== 1'b0) begin
      bad++; $display("FAIL rstmid outputs out_valid=%b res=%h res_is_0=%b illegal=%b want all 0", out_valid, res, res_is_0, illegal);
    end
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) cnt++;
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL rstmid stale result cycles got %0d want 0", cnt); end
    do_op(4'd2, 8'h04, 8'h04, lat, sr);
    total++; if (lat !== 1 || res !== 8'h08) begin bad++; $display("FAIL rstmid recover lat=%0d res=%h want 1/08", lat, res); end
    retire();
  endtask

  task automatic test_back_to_back();
    int ov;
    int badres;
    sel = 4'd2; src1 = 8'h01; src2 = 8'h01;
    in_valid = 1'b1; out_ready = 1'b1;
    ov = 0; badres = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) begin
        ov++;
        if (res !== 8'h02) badres++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (ov !== 4) begin bad++; $display("FAIL b2b result count got %0d want 4", ov); end
    total++; if (badres !== 0) begin bad++; $display("FAIL b2b wrong results got %0d want 0", badres); end
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sel = '0; src1 = '0; src2 = '0;
    test_reset();
    test_single();
    test_shift();
    test_mul();
    test_illegal();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised successor of the processor's combinational ALU.
- Keeps the five single-cycle operations and adds iterative shifts and multiply.
- Wraps all operations in a valid/ready handshake with registered results.
- Sits between decode/operand fetch and writeback; the datapath stalls on in_ready/out_valid.

Parameters:
- DWIDTH, 8: operand and result width in bits; must be >= 2.
- SWIDTH, 3: select width; must be >= 3.
- SHW, $clog2(DWIDTH): derived local parameter; shift-amount width.

Ports:
- clk  input  1  Clock; all state changes on the rising edge.
- rst  input  1  Reset; synchronous, active-high.
- in_valid  input  1  Operation request.
- in_ready  output  1  Block can accept a request.
- sel  input  SWIDTH  Operation select.
- src1  input  DWIDTH  Operand 1.
- src2  input  DWIDTH  Operand 2.
- out_valid  output  1  res, res_is_0 and illegal are valid.
- out_ready  input  1  Consumer accepts the result.
- res  output  DWIDTH  Registered result.
- res_is_0  output  1  Registered (res == 0).
- illegal  output  1  sel was not a legal code; qualified by out_valid.

Behaviour:
- Reset: state = IDLE; res = 0, res_is_0 = 0, illegal = 0, out_valid = 0, iteration counter = 0. in_ready = 1 in the first cycle after reset.
- Reset asserted mid-operation aborts the operation. No result is produced and the outstanding request is dropped.
- States: IDLE, BUSY, DONE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- Accept: a transaction is accepted when in_valid && in_ready; sel, src1 and src2 are captured on that edge. Inputs are don't-care outside IDLE.
- Single-cycle ops, IDLE -> DONE on accept (out_valid on the next cycle):
  - 0 AND: src1 & src2.
  - 1 OR: src1 | src2.
  - 2 ADD: src1 + src2 mod 2^DWIDTH; carry discarded.
  - 6 SUB: src1 + ~src2 + 1 mod 2^DWIDTH.
  - 7 SLT: unsigned src1 < src2, zero-extended to DWIDTH.
- Iterative ops, IDLE -> BUSY on accept:
  - 3 SLL: logical left shift by src2[SHW-1:0], one bit per BUSY cycle.
  - 4 SRL: logical right shift by src2[SHW-1:0], one bit per BUSY cycle, zero-fill.
  - 5 MUL: low DWIDTH bits of the unsigned src1*src2, shift-add, one multiplier bit per BUSY cycle, exactly DWIDTH BUSY cycles.
  - Upper bits of src2 are ignored for shifts.
  - Shift amount 0: go directly to DONE, same as a single-cycle op.
  - BUSY -> DONE on the cycle the last iteration completes.
- Latency, accept edge to first out_valid cycle:
  - Single-cycle ops: 1.
  - Shift by n (n >= 1): n + 1.
  - MUL: DWIDTH + 1.
- illegal: any sel with nonzero bits above [2:0] (only possible when SWIDTH > 3). Goes to DONE with latency 1, res = 0, res_is_0 = 1, illegal = 1. illegal = 0 for all legal results.
- DONE holds res, res_is_0 and illegal stable until out_ready.
  - out_ready while in DONE -> IDLE on the next edge; in_ready is 1 in that following cycle. Back-to-back throughput is therefore at most one op per 2 cycles.
  - out_ready while not in DONE is ignored.
- res_is_0 is registered together with res and always equals (res == 0) while out_valid = 1.
- Arithmetic wraps modulo 2^DWIDTH; no overflow flag.
- Simultaneous in_valid and out_ready in DONE: the result is retired; in_valid is not accepted that cycle.
- Formal environment: only legal handshake behaviour is assumed for the bench.
  - in_valid, sel and operands are stable while in_valid && !in_ready.
- Formal assertions:
  - out_valid implies res_is_0 == (res == 0).
  - res is stable while out_valid && !out_ready.
  - in_ready && out_valid is never true.

Test Plan:
- Reset, then ADD src1 = 8'hF0, src2 = 8'h20, out_ready = 1 -> out_valid 1 cycle after accept, res = 8'h10, res_is_0 = 0; in_ready returns 1 a cycle later.
- SUB src1 = 8'h05, src2 = 8'h05 -> res = 0, res_is_0 = 1. SLT src1 = 3, src2 = 200 -> res = 1. SLT src1 = 200, src2 = 3 -> res = 0.
- SLL src1 = 8'h81, src2 = 8'h03 -> out_valid 4 cycles after accept, res = 8'h08. SRL with src2 = 8'hF8 (amount 0) -> latency 1, res = src1.
- MUL src1 = 13, src2 = 21 -> res = 8'h11 (273 mod 256) after exactly 9 cycles; in_ready = 0 throughout.
- Hold out_ready = 0 for 5 cycles in DONE -> res and out_valid stable, in_valid ignored. Assert rst during MUL BUSY -> next cycle all outputs 0, in_ready = 1, no stale result.
- SWIDTH = 4, sel = 4'b1010 -> illegal = 1, res = 0, res_is_0 = 1, latency 1.
